// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo counter bank: load FSM states and the
// channel-index width helper used to size the load channel select.
package mod_counter_pkg;

  // Load handshake FSM: IDLE accepts a request, APPLY writes it into a channel.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } ld_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter_chan.sv
// One modulo counter channel: up/down stepping with wrap pulse, and a
// load input that overrides stepping and clamps to the top of the range.
// Optional macro MOD_COUNTER_SATURATE_EN turns wrap-around into saturation;
// wrap then flags each cycle a step was blocked at the range edge.
module mod_counter_chan #(
  parameter int              WIDTH   = 16,
  parameter longint unsigned MODULUS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  // Largest legal count; values above it are out of range.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;

  // Next count: load wins, otherwise step in the requested direction.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (load) begin
      count_next = (load_value > MAXV) ? MAXV : load_value;
    end else if (enable) begin
      if (up) begin
        if (count_reg == MAXV) begin
`ifdef MOD_COUNTER_SATURATE_EN
          count_next = count_reg;
`else
          count_next = '0;
`endif
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
`ifdef MOD_COUNTER_SATURATE_EN
          count_next = count_reg;
`else
          count_next = MAXV;
`endif
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end
  end

  // Count and wrap registers; wrap is high in the same cycle as the wrapped count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count = count_reg;
  assign wrap  = wrap_reg;

endmodule

// File: rtl/mod_counter_bank.sv
// Bank of NCH independent modulo counters with a two-cycle load handshake.
// A load request is captured in IDLE and written to its channel in APPLY;
// requests for a channel index >= NCH are accepted and dropped.
// Optional macro MOD_COUNTER_SATURATE_EN selects saturating channels.
module mod_counter_bank
  import mod_counter_pkg::*;
#(
  parameter int              NCH     = 4,
  parameter int              WIDTH   = 16,
  parameter longint unsigned MODULUS = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NCH-1:0]             enable,
  input  logic [NCH-1:0]             up,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [ch_idx_w(NCH)-1:0]   ld_ch,
  input  logic [WIDTH-1:0]           ld_value,
  output logic [NCH*WIDTH-1:0]       count,
  output logic [NCH-1:0]             wrap
);

  localparam int CW = ch_idx_w(NCH);

  ld_state_t        state_reg, state_next;
  logic [CW-1:0]    ld_ch_reg;
  logic [WIDTH-1:0] ld_value_reg;
  logic             accept;

  // Ready only in IDLE and never while reset is held.
  assign ld_ready = reset & (state_reg == IDLE);
  assign accept   = ld_valid & ld_ready;

  // FSM: accept in IDLE, apply for exactly one cycle, then back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = APPLY;
      APPLY:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and captured request; reset drops any pending load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ld_ch_reg    <= '0;
      ld_value_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        ld_ch_reg    <= ld_ch;
        ld_value_reg <= ld_value;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic load_hit;
      // Out-of-range captured channels match no instance, so they are discarded.
      assign load_hit = (state_reg == APPLY) && (ld_ch_reg == CW'(gi));

      mod_counter_chan #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
      ) u_chan (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable[gi]),
        .up         (up[gi]),
        .load       (load_hit),
        .load_value (ld_value_reg),
        .count      (count[gi*WIDTH +: WIDTH]),
        .wrap       (wrap[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mod_counter_bank.sv
// Self-checking bench for mod_counter_bank: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Honours MOD_COUNTER_SATURATE_EN in the model and literal tables.
module tb_mod_counter_bank;
  import mod_counter_pkg::*;

  // Five channels so that a 3-bit ld_ch can address a non-existent channel (6).
  localparam int NCH   = 5;
  localparam int WIDTH = 16;
  localparam int MOD   = 8;
  localparam int CW    = ch_idx_w(NCH);

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NCH-1:0]       enable = '0;
  logic [NCH-1:0]       up = '0;
  logic                 ld_valid = 1'b0;
  logic                 ld_ready;
  logic [CW-1:0]        ld_ch = '0;
  logic [WIDTH-1:0]     ld_value = '0;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       wrap;

  always #5 clock = ~clock;

  mod_counter_bank #(
    .NCH     (NCH),
    .WIDTH   (WIDTH),
    .MODULUS (MOD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .up       (up),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_ch    (ld_ch),
    .ld_value (ld_value),
    .count    (count),
    .wrap     (wrap)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int           m_count [NCH];
  bit [NCH-1:0] m_wrap;
  bit           m_pend;
  int           m_pch;
  int           m_pval;

`ifdef MOD_COUNTER_SATURATE_EN
  int lit_c0 [10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
  int lit_w0 [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  int lit_c1 [3]  = '{0, 0, 0};
  int lit_w1 [3]  = '{1, 1, 1};
`else
  int lit_c0 [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int lit_w0 [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int lit_c1 [3]  = '{7, 6, 5};
  int lit_w1 [3]  = '{1, 0, 0};
`endif

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_count(input int i);
    return int'(count[i*WIDTH +: WIDTH]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_count[i] = 0;
    m_wrap = '0;
    m_pend = 1'b0;
  endtask

  // Apply current inputs to the model, advance one clock edge, commit.
  task automatic step();
    int           nc [NCH];
    bit [NCH-1:0] nw;
    bit           npend;
    int           npch;
    int           npval;
    npend = m_pend;
    npch  = m_pch;
    npval = m_pval;
    nw    = '0;
    for (int i = 0; i < NCH; i++) nc[i] = m_count[i];
    if (!reset) begin
      for (int i = 0; i < NCH; i++) nc[i] = 0;
      npend = 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (m_pend && m_pch == i) begin
          nc[i] = (m_pval >= MOD) ? MOD - 1 : m_pval;
        end else if (enable[i]) begin
`ifdef MOD_COUNTER_SATURATE_EN
          if (up[i]) begin
            if (m_count[i] == MOD - 1) nw[i] = 1'b1;
            else nc[i] = m_count[i] + 1;
          end else begin
            if (m_count[i] == 0) nw[i] = 1'b1;
            else nc[i] = m_count[i] - 1;
          end
`else
          if (up[i]) begin
            nc[i] = (m_count[i] + 1) % MOD;
            nw[i] = (nc[i] == 0);
          end else begin
            nc[i] = (m_count[i] + MOD - 1) % MOD;
            nw[i] = (nc[i] == MOD - 1);
          end
`endif
        end
      end
      if (m_pend) begin
        npend = 1'b0;
      end else if (ld_valid) begin
        npend = 1'b1;
        npch  = int'(ld_ch);
        npval = int'(ld_value);
      end
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NCH; i++) m_count[i] = nc[i];
    m_wrap = nw;
    m_pend = npend;
    m_pch  = npch;
    m_pval = npval;
  endtask

  // Every cycle: compare all outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < NCH; i++)
        chk($sformatf("count%0d", i), longint'(dut_count(i)), longint'(m_count[i]));
      chk("wrap", longint'(wrap), longint'(m_wrap));
      chk("ld_ready", longint'(ld_ready), longint'(reset && !m_pend));
    end
  end

  initial begin
    model_reset();
    m_pch  = 0;
    m_pval = 0;
    chk_en = 1'b1;
    repeat (2) step();
    reset = 1'b1;

    // Channel 0 counts up ten steps; channel 1 counts down for three.
    up = 5'b00001;
    for (int k = 0; k < 10; k++) begin
      enable = (k < 3) ? 5'b00011 : 5'b00001;
      step();
      chk("p1_count0", longint'(dut_count(0)), longint'(lit_c0[k]));
      chk("p1_wrap0", longint'(wrap[0]), longint'(lit_w0[k]));
      if (k < 3) begin
        chk("p1_count1", longint'(dut_count(1)), longint'(lit_c1[k]));
        chk("p1_wrap1", longint'(wrap[1]), longint'(lit_w1[k]));
      end
    end

    // Load channel 2 while it counts up; then an out-of-range value clamps.
    enable   = 5'b00100;
    up       = 5'b11111;
    ld_valid = 1'b1;
    ld_ch    = 3'd2;
    ld_value = 16'd5;
    step();
    chk("p2_ready_low", longint'(ld_ready), 0);
    ld_valid = 1'b0;
    step();
    chk("p2_load5", longint'(dut_count(2)), 5);
    chk("p2_nowrap", longint'(wrap[2]), 0);
    chk("p2_ready_back", longint'(ld_ready), 1);
    ld_valid = 1'b1;
    ld_value = 16'd12;
    step();
    ld_valid = 1'b0;
    step();
    chk("p2_clamp", longint'(dut_count(2)), 7);
    chk("p2_clamp_nowrap", longint'(wrap[2]), 0);
    step();

    // Held ld_valid to a non-existent channel: accepted every other cycle.
    enable   = '0;
    ld_valid = 1'b1;
    ld_ch    = 3'd6;
    ld_value = 16'd3;
    for (int j = 1; j <= 6; j++) begin
      step();
      chk("p3_ready_alt", longint'(ld_ready), longint'(j % 2 == 0));
    end
    ld_valid = 1'b0;
    step();

    // Reset mid-APPLY with nonzero counts.
    enable = 5'b10001;
    repeat (3) step();
    ld_valid = 1'b1;
    ld_ch    = 3'd3;
    ld_value = 16'd4;
    step();
    ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NCH; i++)
      chk("p4_rst_count", longint'(dut_count(i)), 0);
    chk("p4_rst_wrap", longint'(wrap), 0);
    chk("p4_rst_ready", longint'(ld_ready), 0);
    step();
    reset = 1'b1;
    #1;
    chk("p4_ready_after", longint'(ld_ready), 1);
    enable = '0;
    step();
    chk("p4_load_lost", longint'(dut_count(3)), 0);

    // Randomized traffic with occasional reset pulses.
    for (int n = 0; n < 600; n++) begin
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      enable   = NCH'($urandom);
      up       = NCH'($urandom);
      ld_valid = ($urandom_range(0, 2) == 0);
      ld_ch    = CW'($urandom);
      ld_value = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 15));
      step();
    end

    @(negedge clock);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
